// File: rtl/uart_receive.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, byte/valid pulse one cycle after stop sample.
// No backpressure: valid_out/framing_error_out are single-cycle pulses; a low stop bit parks in WAIT_HIGH.
module uart_receive #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_byte_out,
   output logic       valid_out,
   output logic       framing_error_out,
   output logic       busy_out
);

   localparam int PERIOD = CLK_HZ / BAUD_RATE;
   localparam int HALF   = PERIOD / 2;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [7:0]    data_nxt;
   logic          valid_nxt, ferr_nxt;
   logic          rx_meta, rx_s;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rx_meta           <= 1'b1;
         rx_s              <= 1'b1;
         state             <= IDLE;
         cnt               <= '0;
         bit_idx           <= '0;
         shift             <= '0;
         data_byte_out     <= '0;
         valid_out         <= 1'b0;
         framing_error_out <= 1'b0;
      end else begin
         rx_meta           <= rx_wire_in;
         rx_s              <= rx_meta;
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         bit_idx           <= bit_nxt;
         shift             <= shift_nxt;
         data_byte_out     <= data_nxt;
         valid_out         <= valid_nxt;
         framing_error_out <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      data_nxt  = data_byte_out;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == CW'(HALF - 1)) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CW'(PERIOD - 1)) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_s;
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == CW'(PERIOD - 1)) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // a held-low break must see the line recover before the next start edge counts
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Randomized bench for uart_receive: line-level frame driver plus an event-level expected-result queue.
`timescale 1ns/1ps
module tb_uart_receive;
   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 100_000;
   localparam int P      = 16;
   localparam int H      = 8;
   localparam int BIT_NS = P * 10;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       rx_wire_in = 1'b1;
   logic [7:0] data_byte_out;
   logic       valid_out, framing_error_out, busy_out;

   uart_receive #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rx_wire_in(rx_wire_in),
      .data_byte_out(data_byte_out), .valid_out(valid_out),
      .framing_error_out(framing_error_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // observed events, captured away from the active edge
   bit         obs_err[$];
   logic [7:0] obs_byte[$];
   int         obs_cyc[$];
   bit         exp_err[$];
   logic [7:0] exp_byte[$];
   int         cyc = 0;
   int         both_hi = 0;
   int         busy_cnt = 0;
   logic [7:0] last_good = 8'h00;

   always @(negedge clk_in) begin
      cyc++;
      if (busy_out) busy_cnt++;
      if (valid_out && framing_error_out) both_hi++;
      if (valid_out) begin
         obs_err.push_back(1'b0); obs_byte.push_back(data_byte_out); obs_cyc.push_back(cyc);
      end
      if (framing_error_out) begin
         obs_err.push_back(1'b1); obs_byte.push_back(data_byte_out); obs_cyc.push_back(cyc);
      end
   end

   // reference: a frame yields its byte when the stop bit is high, else a framing error
   task automatic expect_frame(input logic [7:0] b, input logic stop);
      exp_err.push_back(!stop);
      exp_byte.push_back(b);
      if (stop) last_good = b;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
      rx_wire_in = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx_wire_in = b[i];
         #(bit_ns);
      end
      rx_wire_in = stop;
      #(bit_ns);
   endtask

   task automatic compare_events(input string tag);
      int n;
      check({tag, "_count"}, obs_err.size(), exp_err.size());
      n = (obs_err.size() < exp_err.size()) ? obs_err.size() : exp_err.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_kind"}, {31'd0, obs_err[i]}, {31'd0, exp_err[i]});
         if (!exp_err[i]) check({tag, "_byte"}, {24'd0, obs_byte[i]}, {24'd0, exp_byte[i]});
      end
      check({tag, "_hold"}, {24'd0, data_byte_out}, {24'd0, last_good});
      obs_err.delete(); obs_byte.delete(); obs_cyc.delete();
      exp_err.delete(); exp_byte.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   initial begin
      logic [7:0] b;
      logic       st;
      int         gap;

      idle(3);
      check("rst_data",  {24'd0, data_byte_out}, 32'h0);
      check("rst_valid", {31'd0, valid_out}, 32'h0);
      check("rst_ferr",  {31'd0, framing_error_out}, 32'h0);
      check("rst_busy",  {31'd0, busy_out}, 32'h0);
      rst_in = 1'b1;
      idle(5);

      // single good frame
      expect_frame(8'hA5, 1'b1);
      send_frame(8'hA5, 1'b1, BIT_NS);
      idle(20);
      check("a5_busy_after", {31'd0, busy_out}, 32'h0);
      compare_events("a5");

      // back-to-back, zero idle gap
      expect_frame(8'h3C, 1'b1);
      expect_frame(8'hC3, 1'b1);
      send_frame(8'h3C, 1'b1, BIT_NS);
      send_frame(8'hC3, 1'b1, BIT_NS);
      idle(20);
      if (obs_cyc.size() == 2) check("b2b_spacing", obs_cyc[1] - obs_cyc[0], 10 * P);
      else                     check("b2b_pulses", obs_cyc.size(), 2);
      compare_events("b2b");

      // 4-cycle glitch
      busy_cnt = 0;
      rx_wire_in = 1'b0;
      idle(4);
      rx_wire_in = 1'b1;
      idle(30);
      check("glitch_busy_cycles", busy_cnt, H);
      compare_events("glitch");

      // stop bit low, line held low afterwards
      expect_frame(8'h55, 1'b0);
      send_frame(8'h55, 1'b0, BIT_NS);
      idle(40);
      check("break_busy", {31'd0, busy_out}, 32'h1);
      compare_events("ferr");
      rx_wire_in = 1'b1;
      idle(30);
      check("break_release_busy", {31'd0, busy_out}, 32'h0);
      compare_events("ferr_after");

      // reset during data bit 4; upper nibble high so the tail cannot fake a start
      b = 8'hF0 | 8'($urandom_range(0, 15));
      fork
         send_frame(b, 1'b1, BIT_NS);
         begin
            idle(5 * P + H);
            rst_in = 1'b0;
            @(negedge clk_in);
            rst_in = 1'b1;
            check("mid_rst_data",  {24'd0, data_byte_out}, 32'h0);
            check("mid_rst_busy",  {31'd0, busy_out}, 32'h0);
            check("mid_rst_valid", {31'd0, valid_out}, 32'h0);
         end
      join
      last_good = 8'h00;
      idle(20);
      compare_events("abort");
      expect_frame(8'h0F, 1'b1);
      send_frame(8'h0F, 1'b1, BIT_NS);
      idle(20);
      compare_events("post_rst");

      // +/-3% transmitter skew
      expect_frame(8'hFF, 1'b1); send_frame(8'hFF, 1'b1, 165); idle(3);
      expect_frame(8'h00, 1'b1); send_frame(8'h00, 1'b1, 165); idle(3);
      expect_frame(8'hFF, 1'b1); send_frame(8'hFF, 1'b1, 155); idle(3);
      expect_frame(8'h00, 1'b1); send_frame(8'h00, 1'b1, 155); idle(20);
      compare_events("skew");

      // random frames, random stop bits and gaps
      for (int k = 0; k < 16; k++) begin
         b   = 8'($urandom);
         st  = ($urandom_range(0, 4) != 0);
         gap = $urandom_range(0, 12);
         expect_frame(b, st);
         send_frame(b, st, BIT_NS);
         if (!st) begin
            idle($urandom_range(0, 30));
            rx_wire_in = 1'b1;
            gap = gap + 2;
         end
         idle(gap);
      end
      idle(20);
      compare_events("rand");

      check("valid_ferr_overlap", both_hi, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 clk_in  input  1  system clock; all logic on its rising edge; one clock domain.
REQ-004 rst_in  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 rx_wire_in  input  1  asynchronous serial line from PC, idle high.
REQ-006 data_byte_out  output  8  last correctly received byte.
REQ-007 valid_out  output  1  one-cycle pulse: data_byte_out updated with a new byte.
REQ-008 framing_error_out  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy_out  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 PERIOD SHALL be CLK_HZ/BAUD_RATE (integer divide, 10416 at defaults), and HALF SHALL be PERIOD/2.
REQ-011 rx_wire_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: in the first cycle with rx_s=0 (cycle t0), go to START and clear the bit-period counter.
REQ-015 START: sample rx_s at t0+HALF; if 1 (glitch), return to IDLE with no output pulse; if 0, go to DATA.
REQ-016 DATA: sample bit i (i=0..7) at t0+HALF+(i+1)*PERIOD and shift it into the shift register at position i; after bit 7, go to STOP.
REQ-017 STOP: sample at t0+HALF+9*PERIOD.
REQ-018 STOP sample = 1: data_byte_out SHALL load the shift register and valid_out SHALL pulse high in the following cycle; go to IDLE.
REQ-019 STOP sample = 0: framing_error_out SHALL pulse high in the following cycle, data_byte_out SHALL be unchanged, and the FSM goes to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_s=1, then go to IDLE; a held-low line (break) SHALL NOT start a new frame.
REQ-021 valid_out and framing_error_out SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-022 data_byte_out SHALL hold its value between valid pulses and SHALL not change during reception.
REQ-023 The bit-period counter SHALL be wide enough for PERIOD-1 (14 bits at defaults); it SHALL reset to 0 at every sample point.
REQ-024 A start edge arriving in the cycle after the return to IDLE SHALL be accepted, so back-to-back frames with zero idle gap are received.
REQ-025 Input is not sampled during IDLE other than for start detection; no oversampling or majority vote is performed.

Reset
REQ-026 While rst_in=0 at a clock edge: FSM goes to IDLE, the counter and bit index go to 0, synchronizer flops go to 1, data_byte_out=8'h00, and valid_out=0, framing_error_out=0, busy_out=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the FSM waits in IDLE for a new falling edge.

Verification (sim parameters CLK_HZ=1_600_000, BAUD_RATE=100_000 -> PERIOD=16, HALF=8)
REQ-028 Send 8'hA5 with a proper stop bit -> exactly one valid_out pulse, data_byte_out=8'hA5, framing_error_out never high, busy_out low after the pulse.
REQ-029 Send 8'h3C then 8'hC3 back-to-back with no idle gap -> two valid_out pulses 10*PERIOD=160 cycles apart, values 8'h3C then 8'hC3.
REQ-030 Drive a 4-cycle low glitch on an idle line -> no pulses; busy_out high for about HALF cycles, then low.
REQ-031 Send 8'h55 with the stop bit low, holding the line low 40 more cycles -> one framing_error_out pulse, data_byte_out keeps its prior value, no new frame until the line returns high.
REQ-032 Assert rst_in=0 for 1 cycle during data bit 4 of a frame -> no pulse for that frame, outputs return to reset values, and a subsequent 8'h0F frame is received correctly.
REQ-033 Skew the transmitter bit period by ±3% relative to PERIOD while sending 8'hFF and 8'h00 -> both bytes received correctly.
